// File: rtl/accumulator_unit_pkg.sv
// Shared types for the accumulator unit: opcode encoding and FSM states.
package accumulator_unit_pkg;

    // Width of the opcode field driven by the instruction decoder.
    localparam int unsigned ACU_OP_W = 4;

    // Encodings are fixed by the decoder; 13..15 are unused and behave as NOP.
    typedef enum logic [ACU_OP_W-1:0] {
        NOP   = 4'd0,
        WRITE = 4'd1,
        INC   = 4'd2,
        DEC   = 4'd3,
        ADD   = 4'd4,
        SUB   = 4'd5,
        ROL   = 4'd6,
        ROR   = 4'd7,
        ROTN  = 4'd8,
        CLR   = 4'd9,
        CLC   = 4'd10,
        STC   = 4'd11,
        CMC   = 4'd12
    } acu_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } acu_state_t;

endpackage

// File: rtl/accumulator_unit_if.sv
// Decoder/data-bus side of the accumulator unit: op handshake plus accumulator outputs.
interface accumulator_unit_if
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();

    localparam int unsigned SHW = $clog2(WIDTH);

    logic             select;
    logic             op_valid;
    logic             op_ready;
    acu_op_t          opcode;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc;
    logic             acc_oe;
    logic             carry;
    logic             busy;
    logic             done;

    // Decoder side: presents ops, observes the accumulator.
    modport master (
        output select,
        output op_valid,
        output opcode,
        output data_in,
        output shamt,
        input  op_ready,
        input  acc,
        input  acc_oe,
        input  carry,
        input  busy,
        input  done
    );

    // Accumulator side.
    modport slave (
        input  select,
        input  op_valid,
        input  opcode,
        input  data_in,
        input  shamt,
        output op_ready,
        output acc,
        output acc_oe,
        output carry,
        output busy,
        output done
    );

endinterface

// File: rtl/accumulator_unit_alu.sv
// Combinational next-value logic for every single-cycle accumulator op.
module acu_alu
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  acu_op_t          opcode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             carry_o
);

    localparam int unsigned SW = WIDTH + 1;

    // WIDTH+1-bit sum so the carry falls out of the top bit.
    logic [WIDTH:0] sum;

    // Decode the op into the next accumulator and carry; unlisted ops hold state.
    always_comb begin
        acc_o   = acc_i;
        carry_o = carry_i;
        sum     = '0;
        unique case (opcode_i)
            WRITE: acc_o = data_i;
            INC: begin
                sum     = {1'b0, acc_i} + SW'(1);
                acc_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            DEC: begin
                acc_o   = acc_i - WIDTH'(1);
                carry_o = |acc_i;  // cleared only on borrow from zero
            end
            ADD: begin
                sum     = {1'b0, acc_i} + {1'b0, data_i} + SW'(carry_i);
                acc_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            SUB: begin
                // Carry in/out is the inverted borrow.
                sum     = {1'b0, acc_i} + {1'b0, ~data_i} + SW'(carry_i);
                acc_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            ROL: begin
                acc_o   = {acc_i[WIDTH-2:0], carry_i};
                carry_o = acc_i[WIDTH-1];
            end
            ROR: begin
                acc_o   = {carry_i, acc_i[WIDTH-1:1]};
                carry_o = acc_i[0];
            end
            CLR: begin
                acc_o   = '0;
                carry_o = 1'b0;
            end
            CLC:     carry_o = 1'b0;
            STC:     carry_o = 1'b1;
            CMC:     carry_o = ~carry_i;
            default: ;  // NOP, ROTN (sequenced by the top) and unused encodings
        endcase
    end

endmodule

// File: rtl/accumulator_unit.sv
// WIDTH-bit accumulator with carry/link flag and a multi-cycle rotate-by-N sequencer.
module accumulator_unit
    import accumulator_unit_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    accumulator_unit_if.slave  bus
);

    acu_state_t       state_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             done_q;
    logic [SHW-1:0]   cnt_q;

    logic             accept;
    logic             start_rotn;
    logic [WIDTH-1:0] alu_acc;
    logic             alu_carry;
    logic [WIDTH-1:0] acc_rotl1;

    acu_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .opcode_i (bus.opcode),
        .acc_i    (acc_q),
        .data_i   (bus.data_in),
        .carry_i  (carry_q),
        .acc_o    (alu_acc),
        .carry_o  (alu_carry)
    );

    // Handshake qualification and the single-bit rotate used while BUSY.
    always_comb begin
        accept     = bus.select & bus.op_valid & (state_q == IDLE);
        start_rotn = (bus.opcode == ROTN) && (bus.shamt != '0);
        acc_rotl1  = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
    end

    // Control FSM with registered accumulator, carry, counter and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (start_rotn) begin
                            // acc is left alone here; rotation happens on BUSY edges.
                            cnt_q   <= bus.shamt;
                            state_q <= BUSY;
                        end else begin
                            acc_q   <= alu_acc;
                            carry_q <= alu_carry;
                            done_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_rotl1;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output drive; acc_oe is a pure pass-through of select.
    always_comb begin
        bus.acc      = acc_q;
        bus.carry    = carry_q;
        bus.done     = done_q;
        bus.busy     = (state_q == BUSY);
        bus.op_ready = (state_q == IDLE);
        bus.acc_oe   = bus.select;
    end

endmodule

// File: tb/tb_accumulator_unit.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against an arithmetic reference model.
module tb_accumulator_unit;
    import accumulator_unit_pkg::*;

    logic clock = 1'b0;
    logic rst4;
    logic rst8;

    always #5 clock = ~clock;

    accumulator_unit_if #(.WIDTH(4)) if4 ();
    accumulator_unit_if #(.WIDTH(8)) if8 ();

    accumulator_unit #(.WIDTH(4)) u_dut4 (.clock(clock), .reset(rst4), .bus(if4.slave));
    accumulator_unit #(.WIDTH(8)) u_dut8 (.clock(clock), .reset(rst8), .bus(if8.slave));

    int errors = 0;
    int checks = 0;
    int m4_acc, m4_c, m8_acc, m8_c;

    // Reference: next {carry, acc} from the op definitions using plain integer arithmetic.
    function automatic void ref_step(input int w, input int op, input int acc, input int c,
                                     input int din, output int nacc, output int nc);
        int mask;
        int s;
        mask = (1 << w) - 1;
        nacc = acc;
        nc   = c;
        case (op)
            1:  nacc = din;
            2:  begin nacc = (acc + 1) & mask; nc = (acc == mask) ? 1 : 0; end
            3:  begin nacc = (acc - 1) & mask; nc = (acc != 0) ? 1 : 0; end
            4:  begin s = acc + din + c; nacc = s & mask; nc = (s >> w) & 1; end
            5:  begin s = acc + ((~din) & mask) + c; nacc = s & mask; nc = (s >> w) & 1; end
            6:  begin nacc = ((acc << 1) | c) & mask; nc = (acc >> (w - 1)) & 1; end
            7:  begin nacc = (acc >> 1) | (c << (w - 1)); nc = acc & 1; end
            9:  begin nacc = 0; nc = 0; end
            10: nc = 0;
            11: nc = 1;
            12: nc = 1 - c;
            default: ;
        endcase
    endfunction

    function automatic int rotl(input int w, input int v, input int k);
        int mask;
        mask = (1 << w) - 1;
        return ((v << k) | (v >> (w - k))) & mask;
    endfunction

    task automatic apply4(input int op, input int din);
        if4.select   = 1'b1;
        if4.op_valid = 1'b1;
        if4.opcode   = acu_op_t'(op[3:0]);
        if4.data_in  = din[3:0];
        if4.shamt    = '0;
        @(negedge clock);
        ref_step(4, op, m4_acc, m4_c, din & 15, m4_acc, m4_c);
    endtask

    task automatic apply8(input int op, input int din);
        if8.select   = 1'b1;
        if8.op_valid = 1'b1;
        if8.opcode   = acu_op_t'(op[3:0]);
        if8.data_in  = din[7:0];
        if8.shamt    = '0;
        @(negedge clock);
        ref_step(8, op, m8_acc, m8_c, din & 255, m8_acc, m8_c);
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1;
        if4.select = 1'b0; if4.op_valid = 1'b0; if4.opcode = NOP;
        if4.data_in = '0; if4.shamt = '0;
        if8.select = 1'b0; if8.op_valid = 1'b0; if8.opcode = NOP;
        if8.data_in = '0; if8.shamt = '0;
        repeat (2) @(negedge clock);
        checks++; if (if4.acc !== 4'h0) begin errors++; $display("FAIL reset_acc: got %h want 0", if4.acc); end
        checks++; if (if4.carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", if4.carry); end
        checks++; if (if4.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if4.op_ready); end
        checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if4.done); end
        checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if4.busy); end
        checks++; if (if4.acc_oe !== 1'b0) begin errors++; $display("FAIL reset_oe_lo: got %b want 0", if4.acc_oe); end
        checks++; if (if8.acc !== 8'h00) begin errors++; $display("FAIL reset_acc8: got %h want 00", if8.acc); end
        if4.select = 1'b1;
        #1;
        checks++; if (if4.acc_oe !== 1'b1) begin errors++; $display("FAIL reset_oe_hi: got %b want 1", if4.acc_oe); end
        @(negedge clock);
        rst4 = 1'b0; rst8 = 1'b0;
        m4_acc = 0; m4_c = 0; m8_acc = 0; m8_c = 0;
        apply4(1, 4'hA);
        checks++; if (if4.acc !== 4'hA) begin errors++; $display("FAIL write_acc: got %h want a", if4.acc); end
        checks++; if (if4.done !== 1'b1) begin errors++; $display("FAIL write_done: got %b want 1", if4.done); end
        if4.op_valid = 1'b0;
        @(negedge clock);
        checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL write_done_pulse: got %b want 0", if4.done); end
    endtask

    task automatic test_inc_add();
        apply4(1, 4'hF);
        apply4(10, 0);
        apply4(2, 0);
        checks++; if (if4.acc !== 4'h0) begin errors++; $display("FAIL inc_wrap_acc: got %h want 0", if4.acc); end
        checks++; if (if4.carry !== 1'b1) begin errors++; $display("FAIL inc_wrap_c: got %b want 1", if4.carry); end
        apply4(4, 4'h7);
        checks++; if (if4.acc !== 4'h8) begin errors++; $display("FAIL add_acc: got %h want 8", if4.acc); end
        checks++; if (if4.carry !== 1'b0) begin errors++; $display("FAIL add_c: got %b want 0", if4.carry); end
        checks++; if (if4.done !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", if4.done); end
    endtask

    task automatic test_sub_dec();
        apply4(1, 4'h3);
        apply4(11, 0);
        apply4(5, 4'h5);
        checks++; if (if4.acc !== 4'hE) begin errors++; $display("FAIL sub_acc: got %h want e", if4.acc); end
        checks++; if (if4.carry !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %b want 0", if4.carry); end
        apply4(1, 4'h0);
        apply4(3, 0);
        checks++; if (if4.acc !== 4'hF) begin errors++; $display("FAIL dec_acc: got %h want f", if4.acc); end
        checks++; if (if4.carry !== 1'b0) begin errors++; $display("FAIL dec_borrow: got %b want 0", if4.carry); end
    endtask

    task automatic test_rotate();
        apply4(1, 4'b1001);
        apply4(10, 0);
        apply4(6, 0);
        checks++; if (if4.acc !== 4'b0010) begin errors++; $display("FAIL rol_acc: got %b want 0010", if4.acc); end
        checks++; if (if4.carry !== 1'b1) begin errors++; $display("FAIL rol_c: got %b want 1", if4.carry); end
        apply4(7, 0);
        checks++; if (if4.acc !== 4'b1001) begin errors++; $display("FAIL ror_acc: got %b want 1001", if4.acc); end
        checks++; if (if4.carry !== 1'b0) begin errors++; $display("FAIL ror_c: got %b want 0", if4.carry); end
    endtask

    task automatic test_select();
        if4.select   = 1'b0;
        if4.op_valid = 1'b1;
        if4.opcode   = INC;
        @(negedge clock);
        checks++; if (if4.acc !== 4'b1001) begin errors++; $display("FAIL nosel_acc: got %h want 9", if4.acc); end
        checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL nosel_done: got %b want 0", if4.done); end
        checks++; if (if4.acc_oe !== 1'b0) begin errors++; $display("FAIL nosel_oe: got %b want 0", if4.acc_oe); end
        if4.op_valid = 1'b0;
    endtask

    // Random back-to-back single-cycle ops, every encoding including unused ones.
    task automatic test_back_to_back();
        int op;
        int din;
        logic [3:0] e_acc;
        logic e_c;
        for (int i = 0; i < 150; i++) begin
            op  = int'($urandom_range(0, 15));
            din = int'($urandom_range(0, 15));
            apply4(op, din);
            e_acc = m4_acc[3:0];
            e_c   = m4_c[0];
            checks++; if (if4.acc !== e_acc) begin errors++; $display("FAIL rand_acc op=%0d: got %h want %h", op, if4.acc, e_acc); end
            checks++; if (if4.carry !== e_c) begin errors++; $display("FAIL rand_c op=%0d: got %b want %b", op, if4.carry, e_c); end
            checks++; if (if4.done !== 1'b1) begin errors++; $display("FAIL rand_done op=%0d: got %b want 1", op, if4.done); end
        end
        if4.op_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rotn_select();
        apply8(1, 8'h81);
        apply8(11, 0);
        if8.opcode = ROTN;
        if8.shamt  = 3'd3;
        @(negedge clock);
        // Next op held from here on; it must wait for op_ready.
        if8.opcode = INC;
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rotn_busy1: got %b want 1", if8.busy); end
        checks++; if (if8.op_ready !== 1'b0) begin errors++; $display("FAIL rotn_ready1: got %b want 0", if8.op_ready); end
        checks++; if (if8.acc !== 8'h81) begin errors++; $display("FAIL rotn_acc1: got %h want 81", if8.acc); end
        if8.select = 1'b0;
        @(negedge clock);
        checks++; if (if8.acc !== 8'h03) begin errors++; $display("FAIL rotn_acc2: got %h want 03", if8.acc); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL rotn_done2: got %b want 0", if8.done); end
        checks++; if (if8.acc_oe !== 1'b0) begin errors++; $display("FAIL rotn_oe2: got %b want 0", if8.acc_oe); end
        if8.select = 1'b1;
        @(negedge clock);
        checks++; if (if8.acc !== 8'h06) begin errors++; $display("FAIL rotn_acc3: got %h want 06", if8.acc); end
        checks++; if (if8.op_ready !== 1'b0) begin errors++; $display("FAIL rotn_ready3: got %b want 0", if8.op_ready); end
        @(negedge clock);
        checks++; if (if8.acc !== 8'h0C) begin errors++; $display("FAIL rotn_final: got %h want 0c", if8.acc); end
        checks++; if (if8.done !== 1'b1) begin errors++; $display("FAIL rotn_done: got %b want 1", if8.done); end
        checks++; if (if8.op_ready !== 1'b1) begin errors++; $display("FAIL rotn_ready4: got %b want 1", if8.op_ready); end
        checks++; if (if8.carry !== 1'b1) begin errors++; $display("FAIL rotn_c: got %b want 1", if8.carry); end
        @(negedge clock);
        if8.op_valid = 1'b0;
        checks++; if (if8.acc !== 8'h0D) begin errors++; $display("FAIL held_inc_acc: got %h want 0d", if8.acc); end
        checks++; if (if8.done !== 1'b1) begin errors++; $display("FAIL held_inc_done: got %b want 1", if8.done); end
        @(negedge clock);
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL held_inc_pulse: got %b want 0", if8.done); end
        m8_acc = 8'h0D; m8_c = 0;
    endtask

    task automatic test_rotn_reset();
        apply8(1, 8'h5A);
        apply8(11, 0);
        if8.opcode = ROTN;
        if8.shamt  = 3'd5;
        @(negedge clock);
        if8.op_valid = 1'b0;
        @(negedge clock);
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", if8.busy); end
        rst8 = 1'b1;
        @(negedge clock);
        checks++; if (if8.acc !== 8'h00) begin errors++; $display("FAIL rst_mid_acc: got %h want 00", if8.acc); end
        checks++; if (if8.carry !== 1'b0) begin errors++; $display("FAIL rst_mid_c: got %b want 0", if8.carry); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got %b want 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", if8.done); end
        rst8 = 1'b0;
        m8_acc = 0; m8_c = 0;
        @(negedge clock);
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL rst_after_done: got %b want 0", if8.done); end
        apply8(1, 8'hB4);
        if8.opcode = ROTN;
        if8.shamt  = 3'd0;
        @(negedge clock);
        if8.op_valid = 1'b0;
        checks++; if (if8.acc !== 8'hB4) begin errors++; $display("FAIL rotn0_acc: got %h want b4", if8.acc); end
        checks++; if (if8.done !== 1'b1) begin errors++; $display("FAIL rotn0_done: got %b want 1", if8.done); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rotn0_busy: got %b want 0", if8.busy); end
    endtask

    task automatic test_rotn_random();
        int v;
        int k;
        logic [7:0] e_acc;
        logic e_c;
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 255));
            k = int'($urandom_range(1, 7));
            apply8(1, v);
            apply8(12, 0);
            if8.opcode = ROTN;
            if8.shamt  = k[2:0];
            m8_acc = rotl(8, m8_acc, k);
            for (int j = 0; j < k; j++) begin
                @(negedge clock);
                if (j == 0) if8.op_valid = 1'b0;
                checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL rrot_busy k=%0d j=%0d: got %b want 1", k, j, if8.busy); end
                checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL rrot_early k=%0d j=%0d: got %b want 0", k, j, if8.done); end
            end
            @(negedge clock);
            e_acc = m8_acc[7:0];
            e_c   = m8_c[0];
            checks++; if (if8.acc !== e_acc) begin errors++; $display("FAIL rrot_acc k=%0d: got %h want %h", k, if8.acc, e_acc); end
            checks++; if (if8.carry !== e_c) begin errors++; $display("FAIL rrot_c k=%0d: got %b want %b", k, if8.carry, e_c); end
            checks++; if (if8.done !== 1'b1) begin errors++; $display("FAIL rrot_done k=%0d: got %b want 1", k, if8.done); end
            checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL rrot_idle k=%0d: got %b want 0", k, if8.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_inc_add();
        test_sub_dec();
        test_rotate();
        test_select();
        test_back_to_back();
        test_rotn_select();
        test_rotn_reset();
        test_rotn_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
